// File: rtl/peak_search_block.sv
// Per-pixel histogram peak finder: scans every bin of every pixel in the
// histogram RAM after a frame and reports the lowest-index bin with the highest count.
//
// state | meaning
// IDLE  | waiting for histReady
// SCAN  | issuing one RAM read per bin of the current pixel
// DRAIN | last bin's data returning; final compare, latch peak outputs
// DONE  | peakDone strobe; advance to next pixel or end the frame
module peak_search_block #(
    parameter int NB        = 6,
    parameter int COUNT_W   = 16,
    parameter int PIXEL_NUM = 16,
    parameter int PIX_W     = $clog2(PIXEL_NUM),
    parameter int MIN_COUNT = 1
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic                  histReady,
    output logic                  ramRdEn,
    output logic [PIX_W+NB-1:0]   ramAddr,
    input  logic [COUNT_W-1:0]    ramData,
    output logic [NB-1:0]         peakCH,
    output logic [COUNT_W-1:0]    peakCount,
    output logic [PIX_W-1:0]      peakPixel,
    output logic                  peakValid,
    output logic                  peakDone,
    output logic                  busy,
    output logic                  frameDone
);

    localparam int BINS = 2 ** NB;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state_q;
    state_t state_d;

    // One extra bit so the last bin is recognised before the counter wraps.
    logic [NB:0]          bin_q;
    logic [PIX_W-1:0]     pix_q;
    logic                 rd_vld_q;
    logic [NB-1:0]        rd_bin_q;
    logic [COUNT_W-1:0]   best_cnt_q;
    logic [COUNT_W-1:0]   best_cnt_d;
    logic [NB-1:0]        best_bin_q;
    logic [NB-1:0]        best_bin_d;
    logic                 last_bin;
    logic                 last_pix;
    logic                 start_pix;
    logic                 upd;

    assign last_bin  = (bin_q == (NB+1)'(BINS - 1));
    assign last_pix  = (pix_q == PIX_W'(PIXEL_NUM - 1));
    assign start_pix = ((state_q == IDLE) && histReady) ||
                       ((state_q == DONE) && !last_pix);

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (histReady) begin
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (last_bin) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                state_d = DONE;
            end
            DONE: begin
                state_d = last_pix ? IDLE : SCAN;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        ramRdEn   = 1'b0;
        ramAddr   = '0;
        peakDone  = 1'b0;
        frameDone = 1'b0;
        busy      = (state_q != IDLE);
        case (state_q)
            SCAN: begin
                ramRdEn = 1'b1;
                ramAddr = {pix_q, bin_q[NB-1:0]};
            end
            DONE: begin
                peakDone  = 1'b1;
                frameDone = last_pix;
            end
            default: begin
            end
        endcase
    end

    // Strict greater-than keeps the lowest bin on ties.
    always_comb begin
        upd        = rd_vld_q && (ramData > best_cnt_q);
        best_cnt_d = best_cnt_q;
        best_bin_d = best_bin_q;
        if (upd) begin
            best_cnt_d = ramData;
            best_bin_d = rd_bin_q;
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            bin_q    <= '0;
            pix_q    <= '0;
            rd_vld_q <= 1'b0;
            rd_bin_q <= '0;
        end else begin
            rd_vld_q <= ramRdEn;
            rd_bin_q <= bin_q[NB-1:0];
            case (state_q)
                IDLE: begin
                    if (histReady) begin
                        pix_q <= '0;
                        bin_q <= '0;
                    end
                end
                SCAN: begin
                    bin_q <= bin_q + (NB+1)'(1);
                end
                DONE: begin
                    bin_q <= '0;
                    if (!last_pix) begin
                        pix_q <= pix_q + PIX_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            best_cnt_q <= '0;
            best_bin_q <= '0;
        end else if (start_pix) begin
            best_cnt_q <= '0;
            best_bin_q <= '0;
        end else begin
            best_cnt_q <= best_cnt_d;
            best_bin_q <= best_bin_d;
        end
    end

    // Latched from the post-compare values so the final bin is included.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            peakCH    <= '0;
            peakCount <= '0;
            peakPixel <= '0;
            peakValid <= 1'b0;
        end else if (state_q == DRAIN) begin
            peakCH    <= best_bin_d;
            peakCount <= best_cnt_d;
            peakPixel <= pix_q;
            peakValid <= (best_cnt_d >= COUNT_W'(MIN_COUNT));
        end
    end

endmodule

// File: tb/tb_peak_search_block.sv
// Scoreboard bench for peak_search_block: directed histograms, expected peaks
// queued at stimulus time and checked by an independent monitor.
module tb_peak_search_block;

    localparam int NB        = 4;
    localparam int COUNT_W   = 16;
    localparam int PIXEL_NUM = 2;
    localparam int PIX_W     = 1;
    localparam int BINS      = 16;
    localparam int PERIOD    = BINS + 2;

    logic                clk = 1'b0;
    logic                res = 1'b0;
    logic                histReady = 1'b0;
    logic                ramRdEn;
    logic [PIX_W+NB-1:0] ramAddr;
    logic [COUNT_W-1:0]  ramData;
    logic [NB-1:0]       peakCH;
    logic [COUNT_W-1:0]  peakCount;
    logic [PIX_W-1:0]    peakPixel;
    logic                peakValid;
    logic                peakDone;
    logic                busy;
    logic                frameDone;

    peak_search_block #(
        .NB(NB), .COUNT_W(COUNT_W), .PIXEL_NUM(PIXEL_NUM), .PIX_W(PIX_W), .MIN_COUNT(1)
    ) dut (
        .clk(clk), .res(res), .histReady(histReady),
        .ramRdEn(ramRdEn), .ramAddr(ramAddr), .ramData(ramData),
        .peakCH(peakCH), .peakCount(peakCount), .peakPixel(peakPixel),
        .peakValid(peakValid), .peakDone(peakDone), .busy(busy), .frameDone(frameDone)
    );

    always #5 clk = ~clk;

    logic [COUNT_W-1:0] mem [0:PIXEL_NUM*BINS-1];

    always @(posedge clk) begin
        if (ramRdEn) ramData <= mem[ramAddr];
    end

    typedef struct {
        int ch;
        int cnt;
        int pix;
        int vld;
        int cyc;
        int fd;
    } exp_t;

    exp_t sb[$];

    int cyc = 0;
    int t0 = 0;
    int checks = 0;
    int errors = 0;
    logic [PIX_W+NB-1:0] exp_addr = '0;
    logic                prev_rd = 1'b0;
    logic [NB-1:0]       prev_bin = '0;
    logic                prev_pd = 1'b0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        int rel;
        exp_t e;
        rel = cyc - t0 + 1;
        if (res) begin
            if (ramRdEn) begin
                check("ram_addr_seq", ramAddr, exp_addr);
                exp_addr++;
            end
            if (prev_rd && prev_bin != 4'(BINS - 1)) check("ram_no_gap", ramRdEn, 1);
            if (peakDone) begin
                check("rd_off_in_done", ramRdEn, 0);
                check("peakdone_single", prev_pd, 0);
                if (sb.size() == 0) begin
                    check("unexpected_peakdone", peakDone, 0);
                end else begin
                    e = sb.pop_front();
                    check("peak_ch", peakCH, e.ch);
                    check("peak_count", peakCount, e.cnt);
                    check("peak_pixel", peakPixel, e.pix);
                    check("peak_valid", peakValid, e.vld);
                    check("peakdone_cycle", rel, e.cyc);
                    check("frame_done", frameDone, e.fd);
                end
            end else if (frameDone) begin
                check("framedone_without_peakdone", frameDone, 0);
            end
            prev_rd  = ramRdEn;
            prev_bin = ramAddr[NB-1:0];
            prev_pd  = peakDone;
        end else begin
            prev_rd = 1'b0;
            prev_pd = 1'b0;
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < PIXEL_NUM * BINS; i++) mem[i] = '0;
    endtask

    task automatic fill(input int p, input int v);
        for (int b = 0; b < BINS; b++) mem[p*BINS + b] = COUNT_W'(v);
    endtask

    task automatic poke(input int p, input int b, input int v);
        mem[p*BINS + b] = COUNT_W'(v);
    endtask

    task automatic push_exp(input int p, input int ch, input int cnt, input int vld);
        exp_t e;
        e.ch  = ch;
        e.cnt = cnt;
        e.pix = p;
        e.vld = vld;
        e.cyc = (p + 1) * PERIOD;
        e.fd  = (p == PIXEL_NUM - 1) ? 1 : 0;
        sb.push_back(e);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rden"}, ramRdEn, 0);
        check({tag, "_addr"}, ramAddr, 0);
        check({tag, "_ch"}, peakCH, 0);
        check({tag, "_count"}, peakCount, 0);
        check({tag, "_pixel"}, peakPixel, 0);
        check({tag, "_valid"}, peakValid, 0);
        check({tag, "_done"}, peakDone, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_frame"}, frameDone, 0);
    endtask

    // pulse_at / abort_at are cycles relative to the histReady sampling edge; 0 disables.
    task automatic run_frame(input int pulse_at, input int abort_at);
        @(negedge clk);
        histReady = 1'b1;
        exp_addr  = '0;
        @(posedge clk);
        #1;
        t0 = cyc;
        histReady = 1'b0;
        for (int r = 1; r <= PIXEL_NUM * PERIOD + 1; r++) begin
            @(negedge clk);
            if (r == 1) check("busy_start", busy, 1);
            if (r == pulse_at) histReady = 1'b1;
            else if (r == pulse_at + 1) histReady = 1'b0;
            if (r == abort_at) begin
                res = 1'b0;
                #1;
                check_all_zero("abort");
                sb.delete();
                exp_addr = '0;
                @(negedge clk);
                @(negedge clk);
                res = 1'b1;
                return;
            end
        end
        check("busy_end", busy, 0);
        check("scoreboard_drained", sb.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        clear_mem();
        repeat (3) @(negedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        res = 1'b1;

        // single dominant peak
        clear_mem();
        fill(0, 3);
        poke(0, 9, 50);
        poke(1, 2, 7);
        push_exp(0, 9, 50, 1);
        push_exp(1, 2, 7, 1);
        run_frame(0, 0);

        // tie at both edge bins, then last bin alone
        clear_mem();
        poke(0, 0, 20);
        poke(0, 15, 20);
        poke(1, 15, 20);
        push_exp(0, 0, 20, 1);
        push_exp(1, 15, 20, 1);
        run_frame(0, 0);

        // empty and saturated
        clear_mem();
        fill(1, 16'hFFFF);
        push_exp(0, 0, 0, 0);
        push_exp(1, 0, 16'hFFFF, 1);
        run_frame(0, 0);

        // count exactly at the validity threshold; adjacent near-equal bins
        clear_mem();
        poke(0, 7, 1);
        poke(1, 3, 99);
        poke(1, 4, 100);
        push_exp(0, 7, 1, 1);
        push_exp(1, 4, 100, 1);
        run_frame(0, 0);

        // histReady during the scan must be ignored
        clear_mem();
        fill(0, 3);
        poke(0, 9, 50);
        poke(1, 2, 7);
        push_exp(0, 9, 50, 1);
        push_exp(1, 2, 7, 1);
        run_frame(5, 0);

        // reset mid-scan, then a clean rescan
        clear_mem();
        poke(0, 12, 40);
        poke(1, 5, 30);
        push_exp(0, 12, 40, 1);
        push_exp(1, 5, 30, 1);
        run_frame(0, 10);
        repeat (2) @(negedge clk);
        push_exp(0, 12, 40, 1);
        push_exp(1, 5, 30, 1);
        run_frame(0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/peak_search_block.md
# peak_search_block

Scans the per-pixel histogram held in the SiFH histogram RAM after each frame and finds the peak bin of every pixel. It sits directly upstream of the algebraic threshold stage. For each pixel in turn it emits the peak channel `peakCH` together with a one-cycle `peakDone` strobe, which the algebraic stage uses to form THminus/THpositive. A sequential FSM drives the RAM read port with a fixed 1-cycle read latency.

## Interface
- `NB`, default `` `Nb `` (parametersSiFH.vh): bin index width; BINS = 2^NB bins per pixel.
- `COUNT_W`, default 16: width of one histogram bin count.
- `PIXEL_NUM`, default `` `PIXEL_NUM_PER_RAM ``: number of pixels stored in one RAM.
- `PIX_W`, default clog2(PIXEL_NUM): pixel index width.
- `MIN_COUNT`, default 1: minimum peak count for a valid peak.

Ports:
- `clk` input, 1 bit: the single clock; all logic is on its rising edge.
- `res` input, 1 bit: reset, asynchronous and active-low.
- `histReady` input, 1 bit: one-cycle pulse meaning the histogram RAM is complete; starts a frame scan.
- `ramRdEn` output, 1 bit: RAM read enable.
- `ramAddr` output, PIX_W+NB bits: read address {pixel, bin}.
- `ramData` input, COUNT_W bits: read data, valid exactly 1 cycle after `ramRdEn`.
- `peakCH` output, NB bits: peak bin of the current pixel.
- `peakCount` output, COUNT_W bits: count at the peak bin.
- `peakPixel` output, PIX_W bits: index of the pixel that `peakCH` belongs to.
- `peakValid` output, 1 bit: peakCount ≥ MIN_COUNT.
- `peakDone` output, 1 bit: one-cycle strobe; the peak* outputs are valid in that cycle and are held afterwards.
- `busy` output, 1 bit: high from the scan start until the frame ends.
- `frameDone` output, 1 bit: one-cycle strobe issued after the last pixel.

## Operation
- States: IDLE, SCAN, DRAIN, DONE.
- IDLE: `histReady`=1 → go to SCAN with pixel=0 and bin=0. Clear best count to 0 and best bin to 0.
- SCAN: assert `ramRdEn` with `ramAddr`={pixel, bin}, and increment bin each cycle. After issuing bin BINS-1, go to DRAIN.
- Compare pipeline: a delayed valid/bin register is paired with `ramData`. Update best when ramData > bestCount (strict), so ties keep the lowest bin.
- DRAIN: compare the last bin's data. Then go to DONE and register peakCH, peakCount, peakPixel, and peakValid = (best ≥ MIN_COUNT).
- DONE: `peakDone`=1 for one cycle. If pixel = PIXEL_NUM-1 → assert `frameDone` in the same cycle and go to IDLE. Otherwise increment pixel, clear best, and go to SCAN.
- All-zero histogram: peakCH=0, peakCount=0, peakValid=0, and `peakDone` still pulses.
- All bins saturated (all ones): peakCH=0 (tie rule).
- `histReady` while busy is ignored and is not queued.
- `histReady` in the same cycle as `frameDone` is ignored. A new scan needs `histReady` while in IDLE.
- Counts are unsigned COUNT_W bits. The comparison is unsigned with no saturation logic, and no arithmetic is done on counts.
- Bin and pixel counters wrap only under FSM control. The bin counter is NB+1 bits internally, or equivalent, so bin BINS-1 is detected without aliasing.

## Timing
- Reset values: ramRdEn=0, ramAddr=0, peakCH=0, peakCount=0, peakPixel=0, peakValid=0, peakDone=0, busy=0, frameDone=0, FSM=IDLE.
- Reset mid-scan aborts the frame immediately. No `peakDone` or `frameDone` is emitted for the aborted frame.
- Let cycle 0 be the edge that samples `histReady`=1. Then:
  - `busy`=1 from cycle 1.
  - Bin b of pixel 0 is read (`ramRdEn`) in cycle 1+b.
  - Its data arrives in cycle 2+b.
- `peakDone` for pixel p occurs in cycle (p+1)·(BINS+2).
- The next pixel's first read is in the cycle after `peakDone`.
- `frameDone` coincides with the last `peakDone`. `busy` drops in the following cycle.
- Per-pixel period is BINS+2 cycles. Frame latency is PIXEL_NUM·(BINS+2) cycles.
- Outputs change only on `clk`, and `peakDone`/`frameDone` are never high for 2 consecutive cycles.

## Test plan
- Single peak (NB=4, PIXEL_NUM=2): pixel 0 has bin 9=50 and all other bins=3; pixel 1 has bin 2=7. Required: `peakDone` in cycle 18 with peakCH=9, peakCount=50, peakPixel=0, peakValid=1. `peakDone` in cycle 36 with peakCH=2, peakPixel=1, and `frameDone` in cycle 36.
- Tie and edge bins: bins 0 and 15 both =20 → peakCH=0. Only bin 15 =20 → peakCH=15.
- Empty and saturated histograms:
  - All zeros → peakCH=0, peakCount=0, peakValid=0, and `peakDone` still pulses.
  - All 0xFFFF → peakCH=0, peakCount=0xFFFF.
- Busy protection: pulse `histReady` in cycle 5 during the scan. Required: no restart, `ramAddr` sequence unchanged, exactly 2 `peakDone` pulses.
- Reset mid-operation: deassert `res` (drive it low) in cycle 10. Required: all outputs 0 immediately. A new `histReady` starts a full clean scan with correct peaks.
- RAM protocol check: in every `ramRdEn` cycle, ramAddr = {pixel, bin} increments by 1 within a pixel with no gaps. `ramRdEn`=0 in the DRAIN and DONE states.
